// File: rtl/vc_bank.sv
// vc_bank: NVC independent circular FIFOs sharing one write port and one
// arbitrated, registered read port. Per-channel full/empty/almost flags are
// registered from the post-update count; drops are reported as one-cycle pulses.
module vc_bank #(
  parameter int BW       = 6,
  parameter int DEPTH    = 16,
  parameter int NVC      = 2,
  parameter int TOL      = 1,
  parameter int ARB_MODE = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           valid_in,
  input  logic [1:0]     vc_sel,
  input  logic [BW-1:0]  data_in,
  input  logic           pop_en,
  output logic [BW-1:0]  data_out,
  output logic           valid_out,
  output logic [1:0]     vc_out,
  output logic [NVC-1:0] full,
  output logic [NVC-1:0] empty,
  output logic [NVC-1:0] almost_full,
  output logic [NVC-1:0] almost_empty,
  output logic [NVC-1:0] error_output,
  output logic           error_sel
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BW-1:0]  r_mem  [NVC][DEPTH];
  logic [AW-1:0]  r_wptr [NVC];
  logic [AW-1:0]  r_rptr [NVC];
  logic [CW-1:0]  r_cnt  [NVC];
  logic [1:0]     r_last;

  logic [NVC-1:0] w_req;
  logic [NVC-1:0] w_wr;
  logic [NVC-1:0] w_drop;
  logic [NVC-1:0] w_rd;
  logic [CW-1:0]  w_cnt_nxt [NVC];
  logic           w_bad;
  logic           w_gnt_vld;
  logic [1:0]     w_gnt;
  logic [BW-1:0]  w_head;

  // Write decode and request set; both use the count at the start of the cycle,
  // so a word written this cycle is never visible to this cycle's arbiter.
  always_comb begin
    w_bad = !reset && valid_in && (int'(vc_sel) >= NVC);
    for (int v = 0; v < NVC; v++) begin
      w_req[v]  = (r_cnt[v] != '0);
      w_wr[v]   = !reset && valid_in && (vc_sel == 2'(v)) && (r_cnt[v] != CW'(DEPTH));
      w_drop[v] = !reset && valid_in && (vc_sel == 2'(v)) && (r_cnt[v] == CW'(DEPTH));
    end
  end

  // Read arbiter: strict priority (highest index) or round robin from last_grant+1.
  // The round-robin loop runs from the farthest candidate to the nearest so the
  // nearest requester is the last (winning) assignment.
  always_comb begin
    int idx;
    idx   = 0;
    w_gnt = '0;
    if (ARB_MODE == 0) begin
      for (int v = 0; v < NVC; v++)
        if (w_req[v]) w_gnt = 2'(v);
    end else begin
      for (int k = NVC; k >= 1; k--) begin
        idx = (int'(r_last) + k) % NVC;
        if (w_req[idx]) w_gnt = 2'(idx);
      end
    end
    w_gnt_vld = !reset && pop_en && (|w_req);
    w_head    = '0;
    for (int v = 0; v < NVC; v++) begin
      w_rd[v] = w_gnt_vld && (w_gnt == 2'(v));
      if (w_gnt == 2'(v)) w_head = r_mem[v][r_rptr[v]];
    end
  end

  // Next count per channel; a simultaneous write and read cancel out.
  always_comb begin
    for (int v = 0; v < NVC; v++) begin
      case ({w_wr[v], w_rd[v]})
        2'b10:   w_cnt_nxt[v] = r_cnt[v] + CW'(1);
        2'b01:   w_cnt_nxt[v] = r_cnt[v] - CW'(1);
        default: w_cnt_nxt[v] = r_cnt[v];
      endcase
    end
  end

  // Channel control state: pointers, counts and registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NVC; v++) begin
        r_wptr[v] <= '0;
        r_rptr[v] <= '0;
        r_cnt[v]  <= '0;
      end
      full         <= '0;
      almost_full  <= '0;
      empty        <= '1;
      almost_empty <= '1;
    end else begin
      for (int v = 0; v < NVC; v++) begin
        if (w_wr[v]) r_wptr[v] <= r_wptr[v] + AW'(1);
        if (w_rd[v]) r_rptr[v] <= r_rptr[v] + AW'(1);
        r_cnt[v]        <= w_cnt_nxt[v];
        full[v]         <= (w_cnt_nxt[v] == CW'(DEPTH));
        empty[v]        <= (w_cnt_nxt[v] == '0);
        almost_full[v]  <= (w_cnt_nxt[v] >= CW'(DEPTH - TOL));
        almost_empty[v] <= (w_cnt_nxt[v] <= CW'(TOL));
      end
    end
  end

  // Storage array; not reset, stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NVC; v++)
      if (w_wr[v]) r_mem[v][r_wptr[v]] <= data_in;
  end

  // Registered read port, round-robin history and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out     <= '0;
      vc_out       <= '0;
      valid_out    <= 1'b0;
      r_last       <= 2'(NVC - 1);
      error_output <= '0;
      error_sel    <= 1'b0;
    end else begin
      valid_out    <= w_gnt_vld;
      error_output <= w_drop;
      error_sel    <= w_bad;
      if (w_gnt_vld) begin
        data_out <= w_head;
        vc_out   <= w_gnt;
        r_last   <= w_gnt;
      end
    end
  end

endmodule

// File: tb/tb_vc_bank.sv
// Scoreboard bench for vc_bank: a 2-channel strict-priority instance (A) and a
// 4-channel round-robin instance (B). Stimulus pushes the expected {vc,data}
// of every granted read; a negedge monitor pops and compares each valid_out.
module tb_vc_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  // Instance A: NVC=2, DEPTH=16, TOL=1, strict priority
  logic       a_valid = 1'b0;
  logic [1:0] a_sel   = 2'd0;
  logic [5:0] a_data  = 6'd0;
  logic       a_pop   = 1'b0;
  logic [5:0] a_dout;
  logic       a_vout;
  logic [1:0] a_vc;
  logic [1:0] a_full, a_empty, a_af, a_ae, a_err;
  logic       a_esel;

  vc_bank #(.BW(6), .DEPTH(16), .NVC(2), .TOL(1), .ARB_MODE(0)) u_a (
    .clk(clk), .reset(reset), .valid_in(a_valid), .vc_sel(a_sel), .data_in(a_data),
    .pop_en(a_pop), .data_out(a_dout), .valid_out(a_vout), .vc_out(a_vc),
    .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .error_output(a_err), .error_sel(a_esel));

  // Instance B: NVC=4, DEPTH=4, TOL=1, round robin
  logic       b_valid = 1'b0;
  logic [1:0] b_sel   = 2'd0;
  logic [5:0] b_data  = 6'd0;
  logic       b_pop   = 1'b0;
  logic [5:0] b_dout;
  logic       b_vout;
  logic [1:0] b_vc;
  logic [3:0] b_full, b_empty, b_af, b_ae, b_err;
  logic       b_esel;

  vc_bank #(.BW(6), .DEPTH(4), .NVC(4), .TOL(1), .ARB_MODE(1)) u_b (
    .clk(clk), .reset(reset), .valid_in(b_valid), .vc_sel(b_sel), .data_in(b_data),
    .pop_en(b_pop), .data_out(b_dout), .valid_out(b_vout), .vc_out(b_vc),
    .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .error_output(b_err), .error_sel(b_esel));

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid_out must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (a_vout === 1'b1) begin
      if (qa.size() == 0) chk("A_unexpected_valid", 32'(a_vout), 32'd0);
      else chk("A_read", {24'd0, a_vc, a_dout}, {24'd0, qa.pop_front()});
    end
    if (b_vout === 1'b1) begin
      if (qb.size() == 0) chk("B_unexpected_valid", 32'(b_vout), 32'd0);
      else chk("B_read", {24'd0, b_vc, b_dout}, {24'd0, qb.pop_front()});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [1:0] s, input logic [5:0] d, input logic p);
    a_valid = v; a_sel = s; a_data = d; a_pop = p;
    cyc();
    a_valid = 1'b0; a_pop = 1'b0;
  endtask

  task automatic b_drive(input logic v, input logic [1:0] s, input logic [5:0] d, input logic p);
    b_valid = v; b_sel = s; b_data = d; b_pop = p;
    cyc();
    b_valid = 1'b0; b_pop = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_empty", 32'(a_empty), 32'h3);
    chk("rst_aempty", 32'(a_ae), 32'h3);
    chk("rst_full", 32'(a_full), 32'h0);
    chk("rst_afull", 32'(a_af), 32'h0);
    chk("rst_valid", 32'(a_vout), 32'h0);
    chk("rst_dout", 32'(a_dout), 32'h0);
    chk("rst_vc", 32'(a_vc), 32'h0);
    chk("rst_err", 32'(a_err), 32'h0);
    chk("rst_esel", 32'(a_esel), 32'h0);
    chk("rst_B_empty", 32'(b_empty), 32'hF);

    // Round robin on B: 0,1,2,3,0
    b_drive(1, 2'd0, 6'h01, 0);
    b_drive(1, 2'd0, 6'h02, 0);
    b_drive(1, 2'd1, 6'h11, 0);
    b_drive(1, 2'd2, 6'h21, 0);
    b_drive(1, 2'd3, 6'h31, 0);
    qb.push_back({2'd0, 6'h01}); qb.push_back({2'd1, 6'h11});
    qb.push_back({2'd2, 6'h21}); qb.push_back({2'd3, 6'h31});
    qb.push_back({2'd0, 6'h02});
    for (int i = 0; i < 5; i++) b_drive(0, 2'd0, 6'd0, 1);
    cyc();
    chk("B_empty_after_rr", 32'(b_empty), 32'hF);
    // Idle pops must not move the round-robin pointer (last grant = 0)
    b_drive(0, 2'd0, 6'd0, 1);
    b_drive(0, 2'd0, 6'd0, 1);
    b_drive(1, 2'd0, 6'h05, 0);
    b_drive(1, 2'd2, 6'h25, 0);
    qb.push_back({2'd2, 6'h25}); qb.push_back({2'd0, 6'h05});
    b_drive(0, 2'd0, 6'd0, 1);
    b_drive(0, 2'd0, 6'd0, 1);
    cyc();

    // Fill VC0 with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      a_drive(1, 2'd0, 6'(i), 0);
      if (i == 15) begin
        chk("fill15_afull", 32'(a_af), 32'h1);
        chk("fill15_full", 32'(a_full), 32'h0);
      end
    end
    chk("fill_full", 32'(a_full), 32'h1);
    chk("fill_empty", 32'(a_empty), 32'h2);

    // Write to full VC0 plus pop: write dropped, head 0x01 read
    qa.push_back({2'd0, 6'h01});
    a_drive(1, 2'd0, 6'h3F, 1);
    chk("full_wrpop_err", 32'(a_err), 32'h1);
    chk("full_wrpop_full", 32'(a_full), 32'h0);
    // Write plus pop on partially filled VC0: count stays 15
    qa.push_back({2'd0, 6'h02});
    a_drive(1, 2'd0, 6'h3E, 1);
    chk("part_wrpop_err", 32'(a_err), 32'h0);
    chk("part_wrpop_afull", 32'(a_af), 32'h1);
    chk("part_wrpop_full", 32'(a_full), 32'h0);
    chk("part_wrpop_empty", 32'(a_empty), 32'h2);
    // Drain remaining 0x03..0x10 then 0x3E
    for (int i = 3; i <= 16; i++) begin
      qa.push_back({2'd0, 6'(i)});
      a_drive(0, 2'd0, 6'd0, 1);
    end
    qa.push_back({2'd0, 6'h3E});
    a_drive(0, 2'd0, 6'd0, 1);
    chk("drain_empty", 32'(a_empty), 32'h3);
    chk("drain_aempty", 32'(a_ae), 32'h3);
    cyc();
    chk("hold_valid", 32'(a_vout), 32'h0);
    chk("hold_dout", 32'(a_dout), 32'h3E);
    chk("hold_vc", 32'(a_vc), 32'h0);

    // Overflow VC1: 17 writes, last one dropped
    for (int i = 0; i < 17; i++) a_drive(1, 2'd1, 6'(6'h20 + i), 0);
    chk("ovf_err", 32'(a_err), 32'h2);
    chk("ovf_full", 32'(a_full), 32'h2);
    cyc();
    chk("ovf_err_pulse", 32'(a_err), 32'h0);
    for (int i = 0; i < 16; i++) begin
      qa.push_back({2'd1, 6'(6'h20 + i)});
      a_drive(0, 2'd0, 6'd0, 1);
    end
    a_drive(0, 2'd0, 6'd0, 1);
    chk("ovf_drain_empty", 32'(a_empty), 32'h3);

    // Strict priority: 1,1,1,0,0,0
    a_drive(1, 2'd0, 6'h0A, 0); a_drive(1, 2'd0, 6'h0B, 0); a_drive(1, 2'd0, 6'h0C, 0);
    a_drive(1, 2'd1, 6'h1A, 0); a_drive(1, 2'd1, 6'h1B, 0); a_drive(1, 2'd1, 6'h1C, 0);
    qa.push_back({2'd1, 6'h1A}); qa.push_back({2'd1, 6'h1B}); qa.push_back({2'd1, 6'h1C});
    qa.push_back({2'd0, 6'h0A}); qa.push_back({2'd0, 6'h0B}); qa.push_back({2'd0, 6'h0C});
    for (int i = 0; i < 6; i++) a_drive(0, 2'd0, 6'd0, 1);
    cyc();

    // Bad selector
    a_drive(1, 2'd3, 6'h15, 0);
    chk("badsel_esel", 32'(a_esel), 32'h1);
    chk("badsel_empty", 32'(a_empty), 32'h3);
    chk("badsel_err", 32'(a_err), 32'h0);
    a_drive(1, 2'd2, 6'h16, 0);
    chk("badsel2_esel", 32'(a_esel), 32'h1);
    cyc();
    chk("badsel_pulse", 32'(a_esel), 32'h0);
    chk("badsel_noread", 32'(a_vout), 32'h0);

    // Reset with 5 words stored; write/pop during reset ignored
    for (int i = 1; i <= 5; i++) a_drive(1, 2'd0, 6'(i), 0);
    chk("pre_rst_empty", 32'(a_empty), 32'h2);
    reset = 1'b1;
    a_drive(1, 2'd1, 6'h2A, 1);
    reset = 1'b0;
    chk("midrst_empty", 32'(a_empty), 32'h3);
    chk("midrst_valid", 32'(a_vout), 32'h0);
    chk("midrst_dout", 32'(a_dout), 32'h0);
    a_drive(0, 2'd0, 6'd0, 1);
    chk("post_rst_noread", 32'(a_vout), 32'h0);
    cyc(); cyc();

    chk("A_queue_drained", 32'(qa.size()), 32'd0);
    chk("B_queue_drained", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
